// File: rtl/instr_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a 1-deep
// output register feeding execute, with valid/ready flow control and flush.
module instr_decode_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_alu_control,
    output logic [1:0]      out_src_a,
    output logic            out_src_b,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_reg_write,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic            out_is_jal,
    output logic            out_is_jalr,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    typedef struct packed {
        logic [3:0]      alu;
        logic [1:0]      src_a;
        logic            src_b;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            illegal;
    } dec_t;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            legal;
    logic            capture;
    dec_t            dec;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.alu       = {f7[5], f3};
                dec.reg_write = 1'b1;
                legal = (f7 == 7'b0) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_OP_IMM: begin
                dec.imm       = imm_i;
                dec.src_b     = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu       = {1'b0, f3};
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'b0);
                end else if (f3 == 3'b101) begin
                    // bit 30 of the word selects arithmetic shift
                    legal   = (f7 == 7'b0) || (f7 == 7'b0100000);
                    dec.alu = {f7[5], f3};
                end
            end
            OPC_LUI: begin
                dec.src_a     = SRC_A_ZERO;
                dec.src_b     = 1'b1;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src_a     = SRC_A_PC;
                dec.src_b     = 1'b1;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.src_a     = SRC_A_PC;
                dec.src_b     = 1'b1;
                dec.imm       = imm_j;
                dec.is_jal    = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.src_a     = SRC_A_RS1;
                dec.src_b     = 1'b1;
                dec.imm       = imm_i;
                dec.is_jalr   = 1'b1;
                dec.reg_write = 1'b1;
                legal         = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                case (f3[2:1])
                    2'b00:   dec.alu = 4'b1000;
                    2'b10:   dec.alu = 4'b0010;
                    2'b11:   dec.alu = 4'b0011;
                    default: legal   = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.src_b     = 1'b1;
                dec.imm       = imm_i;
                dec.is_load   = 1'b1;
                dec.reg_write = 1'b1;
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
            end
            OPC_STORE: begin
                dec.src_b    = 1'b1;
                dec.imm      = imm_s;
                dec.is_store = 1'b1;
                legal        = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            default: legal = 1'b0;
        endcase
        // illegal words still flow to execute, but with no side effects
        if (!legal) begin
            dec.alu       = 4'b0000;
            dec.reg_write = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jal    = 1'b0;
            dec.is_jalr   = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_pc          <= RESET_PC_OUT;
            out_alu_control <= '0;
            out_src_a       <= '0;
            out_src_b       <= 1'b0;
            out_imm         <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_rd          <= '0;
            out_funct3      <= '0;
            out_reg_write   <= 1'b0;
            out_is_load     <= 1'b0;
            out_is_store    <= 1'b0;
            out_is_branch   <= 1'b0;
            out_is_jal      <= 1'b0;
            out_is_jalr     <= 1'b0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid       <= 1'b1;
            out_pc          <= in_pc;
            out_alu_control <= dec.alu;
            out_src_a       <= dec.src_a;
            out_src_b       <= dec.src_b;
            out_imm         <= dec.imm;
            out_rs1         <= in_instr[19:15];
            out_rs2         <= in_instr[24:20];
            out_rd          <= in_instr[11:7];
            out_funct3      <= f3;
            out_reg_write   <= dec.reg_write;
            out_is_load     <= dec.is_load;
            out_is_store    <= dec.is_store;
            out_is_branch   <= dec.is_branch;
            out_is_jal      <= dec.is_jal;
            out_is_jalr     <= dec.is_jalr;
            out_illegal     <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed-vector bench for instr_decode_stage with hand-computed expectations.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_alu_control;
    logic [1:0]  out_src_a;
    logic        out_src_b;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic        out_reg_write, out_is_load, out_is_store, out_is_branch;
    logic        out_is_jal, out_is_jalr, out_illegal;

    int n_chk = 0;
    int n_err = 0;

    instr_decode_stage #(.XLEN(32), .RESET_PC_OUT(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_alu_control(out_alu_control), .out_src_a(out_src_a), .out_src_b(out_src_b),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_reg_write(out_reg_write),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
        .out_is_jalr(out_is_jalr), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one instruction with execute ready and let it land
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);

        // add x3,x1,x2
        send(32'h002081B3, 32'h100);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_alu", {28'b0, out_alu_control}, 32'h0);
        chk("add_rs1", {27'b0, out_rs1}, 32'd1);
        chk("add_rs2", {27'b0, out_rs2}, 32'd2);
        chk("add_rd", {27'b0, out_rd}, 32'd3);
        chk("add_srcb", {31'b0, out_src_b}, 32'd0);
        chk("add_wr", {31'b0, out_reg_write}, 32'd1);
        chk("add_pc", out_pc, 32'h100);

        send(32'h402081B3, 32'h104);
        chk("sub_alu", {28'b0, out_alu_control}, 32'h8);
        chk("sub_ill", {31'b0, out_illegal}, 32'd0);

        // srai x5,x6,3
        send(32'h40335293, 32'h108);
        chk("srai_alu", {28'b0, out_alu_control}, 32'hD);
        chk("srai_imm", out_imm, 32'h00000403);
        chk("srai_srcb", {31'b0, out_src_b}, 32'd1);
        chk("srai_rs1", {27'b0, out_rs1}, 32'd6);
        chk("srai_rd", {27'b0, out_rd}, 32'd5);

        // addi x1,x0,-1
        send(32'hFFF00093, 32'h10C);
        chk("addi_alu", {28'b0, out_alu_control}, 32'h0);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);

        // lui x2,0x12345
        send(32'h12345137, 32'h110);
        chk("lui_srca", {30'b0, out_src_a}, 32'd2);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", {27'b0, out_rd}, 32'd2);

        // bge x1,x2,+8
        send(32'h0020D463, 32'h114);
        chk("bge_alu", {28'b0, out_alu_control}, 32'h2);
        chk("bge_br", {31'b0, out_is_branch}, 32'd1);
        chk("bge_imm", out_imm, 32'd8);
        chk("bge_wr", {31'b0, out_reg_write}, 32'd0);
        chk("bge_f3", {29'b0, out_funct3}, 32'd5);

        // bltu x1,x2,-4
        send(32'hFE20EEE3, 32'h118);
        chk("bltu_alu", {28'b0, out_alu_control}, 32'h3);
        chk("bltu_imm", out_imm, 32'hFFFFFFFC);

        // jal x1,+16
        send(32'h010000EF, 32'h11C);
        chk("jal_flag", {31'b0, out_is_jal}, 32'd1);
        chk("jal_srca", {30'b0, out_src_a}, 32'd1);
        chk("jal_imm", out_imm, 32'd16);

        // sw x2,8(x1)
        send(32'h0020A423, 32'h120);
        chk("sw_flag", {31'b0, out_is_store}, 32'd1);
        chk("sw_imm", out_imm, 32'd8);
        chk("sw_wr", {31'b0, out_reg_write}, 32'd0);

        // lw x5,-4(x1)
        send(32'hFFC0A283, 32'h124);
        chk("lw_flag", {31'b0, out_is_load}, 32'd1);
        chk("lw_imm", out_imm, 32'hFFFFFFFC);

        // illegal encodings
        send(32'h00000000, 32'h128);
        chk("ill0_ill", {31'b0, out_illegal}, 32'd1);
        chk("ill0_valid", {31'b0, out_valid}, 32'd1);
        chk("ill0_wr", {31'b0, out_reg_write}, 32'd0);
        send(32'h4020F1B3, 32'h12C);
        chk("illop_ill", {31'b0, out_illegal}, 32'd1);
        chk("illop_alu", {28'b0, out_alu_control}, 32'h0);
        chk("illop_wr", {31'b0, out_reg_write}, 32'd0);
        send(32'h000090E7, 32'h130);
        chk("illjalr_ill", {31'b0, out_illegal}, 32'd1);
        chk("illjalr_jalr", {31'b0, out_is_jalr}, 32'd0);

        // drain with nothing incoming
        out_ready = 1'b1;
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // backpressure: hold add, offer sub
        send(32'h002081B3, 32'h200);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h402081B3;
        in_pc     = 32'h204;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
            step();
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_alu", {28'b0, out_alu_control}, 32'h0);
            chk("bp_pc", out_pc, 32'h200);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_rel_alu", {28'b0, out_alu_control}, 32'h8);
        chk("bp_rel_pc", out_pc, 32'h204);

        // flush during stall drops both held and incoming
        out_ready = 1'b0;
        in_instr  = 32'h0020D463;
        in_pc     = 32'h208;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("flush_drop", {31'b0, out_valid}, 32'd0);
        chk("flush_pc", out_pc, 32'h204);

        // streaming: one per cycle, no bubbles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 32'h00000013 | (32'(i + 1) << 7);
            in_pc    = 32'h300 + 32'(4 * i);
            step();
            chk("strm_valid", {31'b0, out_valid}, 32'd1);
            chk("strm_rd", {27'b0, out_rd}, 32'(i + 1));
            chk("strm_pc", out_pc, 32'h300 + 32'(4 * i));
            chk("strm_ready", {31'b0, in_ready}, 32'd1);
        end

        // reset mid-stream beats everything
        in_instr = 32'h12345137;
        flush    = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_pc", out_pc, 32'd0);
        chk("mrst_rd", {27'b0, out_rd}, 32'd0);
        chk("mrst_wr", {31'b0, out_reg_write}, 32'd0);
        chk("mrst_imm", out_imm, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- ID pipeline stage of the RV32I soft core.
- Takes fetched instructions over a valid/ready handshake and decodes them into the 4-bit ALU operation code and operand selects.
- Also produces register indices, the immediate and control flags.
- Holds the result in a 1-deep output register that feeds execute.

Parameters:
XLEN, 32, datapath/PC width (only 32 supported)
RESET_PC_OUT, 0, reset value of out_pc

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard held/incoming instruction (branch redirect)
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction address
out_valid  out  1  decoded instruction held
out_ready  in  1  execute accepts held instruction
out_pc  out  32  registered in_pc
out_alu_control  out  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
out_src_a  out  2  00 rs1, 01 pc, 10 zero
out_src_b  out  1  0 rs2, 1 imm
out_imm  out  32  sign-extended immediate for format
out_rs1/out_rs2/out_rd  out  5 each  register indices
out_funct3  out  3  raw funct3
out_reg_write, out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr, out_illegal  out  1 each

Behaviour:
- Reset: every output register 0 (out_pc = RESET_PC_OUT); out_valid=0. in_ready is combinational and is therefore 1 after reset.
- in_ready = !out_valid || out_ready.
- Capture when in_valid && in_ready: next cycle out_valid=1 and all fields are decoded from in_instr. Latency is exactly 1 cycle.
- Held valid with !out_ready: all outputs stable, no capture.
- Valid drains (out_ready=1) with no in_valid: out_valid→0. Data fields may retain old values.
- flush=1: out_valid→0 next cycle regardless of in_valid/out_ready. flush beats capture. rst beats flush.
- Decode (opcode):
  - OP 0110011: alu={f7[5],f3}. Legal if f7=0000000, or f7=0100000 with f3∈{000,101}. src_a=rs1, src_b=rs2, reg_write=1.
  - OP-IMM 0010011: imm=I. f3=001 requires f7=0 → 0001. f3=101: f7=0 → 0101, f7=0100000 → 1101, else illegal. Other f3 → {0,f3}, so ADDI never yields SUB. src_b=imm, reg_write=1.
  - LUI 0110111: ADD, src_a=zero, imm=U, reg_write=1.
  - AUIPC 0010111: ADD, src_a=pc, imm=U, reg_write=1.
  - JAL 1101111: ADD, src_a=pc, imm=J, is_jal=1, reg_write=1.
  - JALR 1100111: requires f3=000. ADD, src_a=rs1, imm=I, is_jalr=1, reg_write=1.
  - BRANCH 1100011: f3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 illegal. src_b=rs2, imm=B, is_branch=1.
  - LOAD 0000011: f3∈{000,001,010,100,101}. ADD, imm=I, is_load=1, reg_write=1.
  - STORE 0100011: f3∈{000,001,010}. ADD, imm=S, is_store=1.
  - Any other opcode, or a failed legality check: out_illegal=1. reg_write/is_*/alu_control all 0. out_valid still 1 so execute can trap.
- rd=x0: reg_write still reflects the opcode. Writeback ignores x0.
- Immediate widths: U = instr[31:12]<<12; B and J have LSB=0; all formats sign-extend from instr[31].

Test Plan:
- Directed decode: 0x002081B3 (add x3,x1,x2) → 1 cycle later out_valid=1, alu=0000, rs1=1, rs2=2, rd=3, src_b=0, reg_write=1.
- Directed decode: 0x402081B3 → alu=1000. 0x40335293 (srai x5,x6,3) → alu=1101, imm=0x00000403, src_b=1. 0xFFF00093 (addi x1,x0,-1) → alu=0000, imm=0xFFFFFFFF.
- Directed decode: 0x12345137 (lui x2) → src_a=10, imm=0x12345000. Branches bge/bltu → alu 0010/0011, is_branch=1.
- Backpressure: hold out_ready=0 with out_valid=1 → in_ready=0 and outputs unchanged for 5 cycles. Release → next instruction captured the same cycle out_ready rises.
- Flush during stall: in_valid=1 and flush=1 in the same cycle → out_valid=0 next cycle and the instruction is dropped.
- Reset mid-stream: rst=1 → all outputs 0 next cycle.
- Illegal encodings: 0x00000000, and OP with f7=0100000 f3=111 → out_illegal=1, reg_write=0, out_valid=1.
- Streaming: back-to-back in_valid with out_ready=1 → one decoded instruction per cycle, no bubbles.
